// File: rtl/dct_da_seq.sv
// rtl/dct_da_seq.sv - sequencer for a bit-serial distributed-arithmetic DCT coefficient unit
// Accepts one sample block, walks the datapath through load/shift/sign cycles, then captures the result.
module dct_da_seq #(
    parameter int DATA_W        = 8,
    parameter int N_SMP         = 8,
    parameter int ACC_W         = 18,
    parameter int BLK_PER_FRAME = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_SMP*DATA_W-1:0]    in_data,
    output logic [N_SMP*DATA_W-1:0]    dp_samples,
    output logic                       dp_load,
    output logic                       dp_acc_clr,
    output logic                       dp_shift_en,
    output logic [$clog2(DATA_W)-1:0]  dp_bit_idx,
    output logic                       dp_sign_cyc,
    output logic                       dp_rom_cs,
    input  logic [ACC_W-1:0]           acc_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ACC_W-1:0]           out_data,
    output logic                       out_last,
    output logic                       busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int BLK_W = (BLK_PER_FRAME > 1) ? $clog2(BLK_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(BLK_PER_FRAME - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [BLK_W-1:0]          blk_cnt_q, blk_cnt_d;
    logic [N_SMP*DATA_W-1:0]   samples_q, samples_d;
    logic                      out_valid_q, out_valid_d;
    logic [ACC_W-1:0]          out_data_q, out_data_d;
    logic                      out_last_q, out_last_d;
    logic                      frame_end;

    assign frame_end = (blk_cnt_q == LAST_BLK);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        blk_cnt_d   = blk_cnt_q;
        samples_d   = samples_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        in_ready    = 1'b0;
        dp_load     = 1'b0;
        dp_acc_clr  = 1'b0;
        dp_shift_en = 1'b0;
        dp_rom_cs   = 1'b0;
        dp_sign_cyc = 1'b0;
        dp_bit_idx  = '0;

        // A downstream drain is honoured even while the sequencer is frozen.
        if (out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                in_ready = en;
                if (en && in_valid) begin
                    samples_d = in_data;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                dp_load    = en;
                dp_acc_clr = en;
                dp_rom_cs  = 1'b1;
                if (en) begin
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dp_shift_en = en;
                dp_rom_cs   = 1'b1;
                dp_bit_idx  = bit_cnt_q;
                dp_sign_cyc = (bit_cnt_q == LAST_BIT);
                if (en) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CAPTURE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CAPTURE: begin
                // Datapath stays idle here so acc_in is stable until the output slot frees.
                if (en && (!out_valid_q || out_ready)) begin
                    out_data_d  = acc_in;
                    out_valid_d = 1'b1;
                    out_last_d  = frame_end;
                    blk_cnt_d   = frame_end ? '0 : blk_cnt_q + BLK_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            blk_cnt_q   <= '0;
            samples_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            blk_cnt_q   <= blk_cnt_d;
            samples_q   <= samples_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign dp_samples = samples_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dct_da_seq.sv
// tb/tb_dct_da_seq.sv - self-checking bench for dct_da_seq
// A behavioural DA datapath feeds acc_in; results are checked against a direct dot product.
module tb_dct_da_seq;

    localparam int DATA_W = 8;
    localparam int N_SMP  = 8;
    localparam int ACC_W  = 18;
    localparam int BLK    = 4;
    localparam int COEF [8] = '{23, -41, 57, -12, 64, -64, 5, 31};

    logic                      clk;
    logic                      reset;
    logic                      en;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_SMP*DATA_W-1:0]   in_data;
    logic [N_SMP*DATA_W-1:0]   dp_samples;
    logic                      dp_load;
    logic                      dp_acc_clr;
    logic                      dp_shift_en;
    logic [2:0]                dp_bit_idx;
    logic                      dp_sign_cyc;
    logic                      dp_rom_cs;
    logic [ACC_W-1:0]          acc_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [ACC_W-1:0]          out_data;
    logic                      out_last;
    logic                      busy;

    dct_da_seq #(
        .DATA_W(DATA_W), .N_SMP(N_SMP), .ACC_W(ACC_W), .BLK_PER_FRAME(BLK)
    ) dut (
        .clk(clk), .reset(reset), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dp_samples(dp_samples), .dp_load(dp_load), .dp_acc_clr(dp_acc_clr),
        .dp_shift_en(dp_shift_en), .dp_bit_idx(dp_bit_idx), .dp_sign_cyc(dp_sign_cyc),
        .dp_rom_cs(dp_rom_cs), .acc_in(acc_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          exp_q [$];
    int          out_cnt = 0;
    int          dp_acc = 0;
    int          shift_cnt = 0;
    logic [63:0] lat_data = '0;
    logic        hold_prev = 1'b0;
    logic [17:0] hold_data = '0;
    logic        hold_last = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic int dot(input logic [63:0] d);
        int s = 0;
        for (int i = 0; i < N_SMP; i++) begin
            s += int'($signed(d[8*i +: 8])) * COEF[i];
        end
        return s;
    endfunction

    function automatic logic [17:0] dot18(input logic [63:0] d);
        int s;
        s = dot(d);
        return s[17:0];
    endfunction

    task automatic model_clear();
        exp_q.delete();
        out_cnt   = 0;
        dp_acc    = 0;
        shift_cnt = 0;
        lat_data  = '0;
        hold_prev = 1'b0;
        acc_in    = '0;
    endtask

    // Called mid-cycle: plays the datapath and the scoreboard off the observed strobes.
    task automatic observe();
        int          rom;
        int          term;
        int          ev;
        logic [17:0] e18;
        if (!reset) return;
        if (!en) begin
            check_eq("en0_load", dp_load, 0);
            check_eq("en0_shift", dp_shift_en, 0);
            check_eq("en0_ready", in_ready, 0);
        end
        check_eq("samples", dp_samples, lat_data);
        if (hold_prev) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, hold_data);
            check_eq("hold_last", out_last, hold_last);
        end
        if (dp_load) begin
            check_eq("load_clr", dp_acc_clr, 1);
            check_eq("load_cs", dp_rom_cs, 1);
            dp_acc    = 0;
            shift_cnt = 0;
            acc_in    = '0;
        end
        if (dp_shift_en) begin
            check_eq("bit_idx", dp_bit_idx, shift_cnt);
            check_eq("sign_cyc", dp_sign_cyc, shift_cnt == DATA_W - 1);
            check_eq("shift_cs", dp_rom_cs, 1);
            rom = 0;
            for (int i = 0; i < N_SMP; i++) begin
                if (dp_samples[8*i + int'(dp_bit_idx)]) rom += COEF[i];
            end
            term = rom * (1 << dp_bit_idx);
            dp_acc = dp_sign_cyc ? dp_acc - term : dp_acc + term;
            shift_cnt++;
            acc_in = dp_acc[17:0];
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", 1, 0);
            end else begin
                ev  = exp_q.pop_front();
                e18 = ev[17:0];
                check_eq("out_data", out_data, e18);
                check_eq("out_last", out_last, (out_cnt % BLK) == BLK - 1);
                out_cnt++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(dot(in_data));
            lat_data = in_data;
        end
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
        hold_last = out_last;
    endtask

    task automatic sample();
        @(negedge clk);
        observe();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        advance();
        reset = 1'b1;
    endtask

    task automatic accept_block(input logic [63:0] d, input string tag);
        en       = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        sample();
        check_eq(tag, in_ready, 1);
        advance();
    endtask

    logic [63:0] blk_a;
    logic [63:0] blk_b;

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        acc_in    = '0;

        // Reset state
        sample();
        check_eq("rst_flags", {out_valid, out_last, dp_load, dp_acc_clr, dp_shift_en,
                               dp_rom_cs, dp_sign_cyc, busy}, 0);
        check_eq("rst_data", out_data, 0);
        check_eq("rst_samples", dp_samples, 0);
        check_eq("rst_idx", dp_bit_idx, 0);
        advance();
        reset = 1'b1;

        // Single block timing
        out_ready = 1'b1;
        blk_a = 64'h0102030405060708;
        accept_block(blk_a, "t1_accept");
        in_valid = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            sample();
            check_eq("t1_load", dp_load, k == 1);
            check_eq("t1_clr", dp_acc_clr, k == 1);
            check_eq("t1_shift", dp_shift_en, (k >= 2) && (k <= 9));
            if (k >= 2 && k <= 9) check_eq("t1_idx", dp_bit_idx, k - 2);
            check_eq("t1_sign", dp_sign_cyc, k == 9);
            check_eq("t1_valid", out_valid, k == 11);
            if (k == 11) check_eq("t1_data", out_data, dot18(blk_a));
            advance();
        end

        // Back-to-back blocks, frame marker on every 4th output
        do_reset();
        out_ready = 1'b1;
        accept_block({$urandom, $urandom}, "b2b_accept0");
        for (int k = 1; k <= 88; k++) begin
            in_data = {$urandom, $urandom};
            sample();
            check_eq("b2b_ready", in_ready, (k % 11) == 0);
            check_eq("b2b_valid", out_valid, (k % 11) == 0);
            if ((k % 11) == 0) check_eq("b2b_last", out_last, (k == 44) || (k == 88));
            advance();
        end
        in_valid = 1'b0;

        // Backpressure: second block waits in capture until the first drains
        do_reset();
        blk_a = {$urandom, $urandom};
        blk_b = {$urandom, $urandom};
        accept_block(blk_a, "bp_acceptA");
        in_data = blk_b;
        for (int k = 1; k <= 26; k++) begin
            if (k == 12) in_valid = 1'b0;
            if (k == 25) out_ready = 1'b1;
            if (k == 26) out_ready = 1'b0;
            sample();
            if (k == 11) check_eq("bp_acceptB", in_ready, 1);
            if (k >= 21 && k <= 25) begin
                check_eq("bp_stall_ready", in_ready, 0);
                check_eq("bp_stall_shift", dp_shift_en, 0);
                check_eq("bp_stall_busy", busy, 1);
                check_eq("bp_stall_data", out_data, dot18(blk_a));
            end
            if (k == 26) begin
                check_eq("bp_valid", out_valid, 1);
                check_eq("bp_dataB", out_data, dot18(blk_b));
                check_eq("bp_idle", busy, 0);
            end
            advance();
        end
        out_ready = 1'b1;
        sample();
        advance();
        sample();
        check_eq("bp_drained", out_valid, 0);
        advance();

        // Enable low for three cycles at bit 4
        do_reset();
        out_ready = 1'b1;
        accept_block({$urandom, $urandom}, "en_accept");
        in_valid = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            en = !(k >= 6 && k <= 8);
            sample();
            if (k >= 6 && k <= 8) begin
                check_eq("en_hold_shift", dp_shift_en, 0);
                check_eq("en_hold_idx", dp_bit_idx, 4);
            end
            if (k == 9) begin
                check_eq("en_resume", dp_shift_en, 1);
                check_eq("en_resume_idx", dp_bit_idx, 4);
            end
            if (k == 10) check_eq("en_next_idx", dp_bit_idx, 5);
            check_eq("en_valid", out_valid, k == 14);
            advance();
        end
        en = 1'b1;

        // Reset pulse in the middle of a block
        do_reset();
        out_ready = 1'b1;
        accept_block({$urandom, $urandom}, "mr_accept");
        in_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            sample();
            if (k == 8) check_eq("mr_idx", dp_bit_idx, 6);
            if (k < 8) advance();
        end
        reset = 1'b0;
        model_clear();
        #1;
        check_eq("mr_flags", {dp_shift_en, dp_rom_cs, dp_load, dp_sign_cyc, busy, out_valid}, 0);
        check_eq("mr_idx0", dp_bit_idx, 0);
        check_eq("mr_samples", dp_samples, 0);
        advance();
        reset = 1'b1;
        sample();
        check_eq("mr_ready", in_ready, 1);
        check_eq("mr_busy", busy, 0);
        advance();
        for (int k = 0; k < 15; k++) begin
            sample();
            check_eq("mr_no_out", out_valid, 0);
            advance();
        end

        // in_valid pulsed while a block is in flight
        do_reset();
        out_ready = 1'b1;
        accept_block({$urandom, $urandom}, "iv_accept");
        in_data = {$urandom, $urandom};
        for (int k = 1; k <= 6; k++) begin
            sample();
            check_eq("iv_ready", in_ready, 0);
            advance();
        end
        in_valid = 1'b0;
        repeat (8) begin
            sample();
            advance();
        end

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 500; k++) begin
            en        = ($urandom % 8) != 0;
            in_valid  = $urandom % 2;
            out_ready = ($urandom % 3) != 0;
            in_data   = {$urandom, $urandom};
            sample();
            advance();
        end
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (30) begin
            sample();
            advance();
        end
        check_eq("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
